decode_interlock: RTL and testbench

DECODE_INTERLOCK -- requirements
Module: decode_interlock

---
 rtl/decode_interlock.sv | 131 +++++++++++++
 tb/tb_decode_interlock.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_interlock.sv
// Decode stage with register file, WB bypass, and load-use interlock feeding the ID/EX pipeline register.
`default_nettype none

module decode_interlock #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ex_stall_c,
  input  logic              mem_stall_c,
  input  logic              flush_c,
  input  logic              wb_we,
  input  logic [$clog2(NREGS)-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              if_id_valid,
  input  logic [ADDR_W-1:0] if_id_next_pc,
  input  logic [31:0]       if_id_ir,
  output logic              id_ex_valid,
  output logic [ADDR_W-1:0] id_ex_next_pc,
  output logic [DATA_W-1:0] id_ex_a,
  output logic [DATA_W-1:0] id_ex_b,
  output logic [15:0]       id_ex_imm,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic [5:0]        id_ex_op,
  output logic [1:0]        id_ex_type,
  output logic              id_ex_is_load,
  output logic              id_stall_c,
  output logic [CNT_W-1:0]  load_use_cnt
);

  localparam int REG_AW = $clog2(NREGS);

  logic [DATA_W-1:0] rf [NREGS];

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [REG_AW-1:0] rs_idx, rt_idx;
  logic [1:0]        dec_type;
  logic [5:0]        dec_op;
  logic              dec_load;
  logic              uses_rt;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic              load_use;
  logic              down_stall;

  assign opcode = if_id_ir[31:26];
  assign rs     = if_id_ir[25:21];
  assign rt     = if_id_ir[20:16];
  assign rd     = if_id_ir[15:11];
  assign rs_idx = rs[REG_AW-1:0];
  assign rt_idx = rt[REG_AW-1:0];

  always_comb begin
    dec_type = 2'b00;
    if (opcode == 6'd0 && if_id_ir[25:0] != 26'd0) dec_type = 2'b11;
    else if (opcode[5:2] != 4'd0)                  dec_type = 2'b10;
    else if (opcode[1])                            dec_type = 2'b01;
    dec_op   = (dec_type == 2'b11) ? if_id_ir[5:0] : opcode;
    dec_load = (opcode[5:3] == 3'b100) && (dec_type == 2'b10);
    uses_rt  = (dec_type == 2'b11) || (opcode[5:3] == 3'b101) ||
               (opcode == 6'b000100) || (opcode == 6'b000101);
  end

  // Same-cycle writeback wins over the stale RF entry; r0 is hard-wired to zero.
  always_comb begin
    opnd_a = rf[rs_idx];
    if (rs_idx == '0)                       opnd_a = '0;
    else if (wb_we && wb_dest == rs_idx)    opnd_a = wb_value;
    opnd_b = rf[rt_idx];
    if (rt_idx == '0)                       opnd_b = '0;
    else if (wb_we && wb_dest == rt_idx)    opnd_b = wb_value;
  end

  assign load_use = if_id_valid && id_ex_valid && id_ex_is_load && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));
  assign down_stall = ex_stall_c | mem_stall_c;
  assign id_stall_c = !flush_c && (down_stall || load_use);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we && wb_dest != '0) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // A bubble is inserted on flush, on an unstalled load-use hazard, or when IF/ID is empty.
  always_ff @(posedge clock) begin
    if (!reset_n || flush_c || (!down_stall && (load_use || !if_id_valid))) begin
      id_ex_valid   <= 1'b0;
      id_ex_next_pc <= '0;
      id_ex_a       <= '0;
      id_ex_b       <= '0;
      id_ex_imm     <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_rd      <= '0;
      id_ex_op      <= '0;
      id_ex_type    <= '0;
      id_ex_is_load <= 1'b0;
    end else if (!down_stall) begin
      id_ex_valid   <= 1'b1;
      id_ex_next_pc <= if_id_next_pc;
      id_ex_a       <= opnd_a;
      id_ex_b       <= opnd_b;
      id_ex_imm     <= if_id_ir[15:0];
      id_ex_rs      <= rs;
      id_ex_rt      <= rt;
      id_ex_rd      <= rd;
      id_ex_op      <= dec_op;
      id_ex_type    <= dec_type;
      id_ex_is_load <= dec_load;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      load_use_cnt <= '0;
    end else if (!flush_c && !down_stall && load_use && load_use_cnt != '1) begin
      load_use_cnt <= load_use_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_interlock.sv
// Scoreboard bench for decode_interlock: default instance plus a narrow NREGS=8/DATA_W=16/CNT_W=2 instance.
`default_nettype none

module tb_decode_interlock;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op;
    logic [1:0]  typ;
    logic        ld;
  } idex_t;

  typedef struct packed {
    idex_t       st;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        rn, fl, es, ms, we;
    logic [4:0]  dst;
    logic [31:0] val;
    logic        v;
    logic [31:0] ir;
  } stim_t;

  logic clock, reset_n, ex_stall_c, mem_stall_c, flush_c, wb_we, if_id_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value, if_id_next_pc, if_id_ir;
  logic        id_ex_valid, id_ex_is_load, id_stall_c;
  logic [31:0] id_ex_next_pc, id_ex_a, id_ex_b;
  logic [15:0] id_ex_imm, load_use_cnt;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [5:0]  id_ex_op;
  logic [1:0]  id_ex_type;

  logic        s_wb_we;
  logic [2:0]  s_wb_dest;
  logic [15:0] s_wb_value;
  logic        s_valid, s_is_load, s_stall;
  logic [31:0] s_next_pc;
  logic [15:0] s_a, s_b, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [5:0]  s_op;
  logic [1:0]  s_type;
  logic [1:0]  s_cnt;

  decode_interlock dut (
    .clock(clock), .reset_n(reset_n), .ex_stall_c(ex_stall_c), .mem_stall_c(mem_stall_c),
    .flush_c(flush_c), .wb_we(wb_we), .wb_dest(wb_dest), .wb_value(wb_value),
    .if_id_valid(if_id_valid), .if_id_next_pc(if_id_next_pc), .if_id_ir(if_id_ir),
    .id_ex_valid(id_ex_valid), .id_ex_next_pc(id_ex_next_pc), .id_ex_a(id_ex_a), .id_ex_b(id_ex_b),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_op(id_ex_op), .id_ex_type(id_ex_type), .id_ex_is_load(id_ex_is_load),
    .id_stall_c(id_stall_c), .load_use_cnt(load_use_cnt)
  );

  decode_interlock #(.DATA_W(16), .ADDR_W(32), .NREGS(8), .CNT_W(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .ex_stall_c(ex_stall_c), .mem_stall_c(mem_stall_c),
    .flush_c(flush_c), .wb_we(s_wb_we), .wb_dest(s_wb_dest), .wb_value(s_wb_value),
    .if_id_valid(if_id_valid), .if_id_next_pc(if_id_next_pc), .if_id_ir(if_id_ir),
    .id_ex_valid(s_valid), .id_ex_next_pc(s_next_pc), .id_ex_a(s_a), .id_ex_b(s_b),
    .id_ex_imm(s_imm), .id_ex_rs(s_rs), .id_ex_rt(s_rt), .id_ex_rd(s_rd),
    .id_ex_op(s_op), .id_ex_type(s_type), .id_ex_is_load(s_is_load),
    .id_stall_c(s_stall), .load_use_cnt(s_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  exp_t  sb[$];
  idex_t m_cur;
  logic [15:0] m_cnt;
  logic [31:0] m_rf [32];
  logic [31:0] pc_ctr = 32'h1000;

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs, rt);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction
  function automatic stim_t mk(input logic rn, fl, es, ms, we, input logic [4:0] dst,
                               input logic [31:0] val, input logic v, input logic [31:0] ir);
    stim_t s;
    s.rn = rn; s.fl = fl; s.es = es; s.ms = ms; s.we = we;
    s.dst = dst; s.val = val; s.v = v; s.ir = ir;
    return s;
  endfunction
  function automatic stim_t nv(input logic [31:0] ir);
    return mk(1, 0, 0, 0, 0, 5'd0, 32'd0, 1, ir);
  endfunction

  function automatic idex_t obs_idex();
    return {id_ex_valid, id_ex_next_pc, id_ex_a, id_ex_b, id_ex_imm, id_ex_rs, id_ex_rt,
            id_ex_rd, id_ex_op, id_ex_type, id_ex_is_load};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_dest == idx) return wb_value;
    return m_rf[idx];
  endfunction

  function automatic idex_t decode_model();
    idex_t r;
    logic [5:0] opc;
    opc = if_id_ir[31:26];
    r = '0;
    r.valid = 1'b1; r.pc = if_id_next_pc; r.imm = if_id_ir[15:0];
    r.rs = if_id_ir[25:21]; r.rt = if_id_ir[20:16]; r.rd = if_id_ir[15:11];
    if (opc == 6'd0 && if_id_ir[25:0] != 26'd0) begin
      r.typ = 2'b11; r.op = if_id_ir[5:0];
    end else begin
      r.op = opc;
      if (opc[5:2] != 4'd0) r.typ = 2'b10;
      else if (opc[1])      r.typ = 2'b01;
      else                  r.typ = 2'b00;
    end
    r.ld = (opc[5:3] == 3'b100) && (r.typ == 2'b10);
    r.a = rd_model(r.rs);
    r.b = rd_model(r.rt);
    return r;
  endfunction

  function automatic logic hazard_model();
    logic [5:0] opc;
    logic rtuse;
    opc = if_id_ir[31:26];
    rtuse = (opc == 6'd0 && if_id_ir[25:0] != 26'd0) || opc[5:3] == 3'b101 ||
            opc == 6'b000100 || opc == 6'b000101;
    return if_id_valid && m_cur.valid && m_cur.ld && m_cur.rt != 5'd0 &&
           (m_cur.rt == if_id_ir[25:21] || (rtuse && m_cur.rt == if_id_ir[20:16]));
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clock);
    reset_n = s.rn; flush_c = s.fl; ex_stall_c = s.es; mem_stall_c = s.ms;
    wb_we = s.we; wb_dest = s.dst; wb_value = s.val;
    if_id_valid = s.v; if_id_ir = s.ir; if_id_next_pc = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    #1;
  endtask

  // Advances the reference model by one edge and queues what ID/EX must hold afterwards.
  task automatic predict();
    idex_t nxt;
    exp_t  e;
    logic  hz;
    hz  = hazard_model();
    nxt = m_cur;
    if (!reset_n) begin
      nxt = '0; m_cnt = 16'd0;
    end else if (flush_c) begin
      nxt = '0;
    end else if (ex_stall_c || mem_stall_c) begin
      nxt = m_cur;
    end else if (hz) begin
      nxt = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (if_id_valid) begin
      nxt = decode_model();
    end else begin
      nxt = '0;
    end
    m_cur = nxt;
    e.st = nxt; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else if (wb_we && wb_dest != 5'd0) begin
      m_rf[wb_dest] = wb_value;
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t vec[$];
    exp_t e;
    logic es;
    vec.push_back(mk(0, 0, 0, 1, 1, 5'd3, 32'hAAAA_5555, 1, r_add(5'd5, 5'd3, 5'd0)));
    vec.push_back(nv(r_add(5'd5, 5'd3, 5'd0)));
    foreach (vec[i]) begin
      apply(vec[i]);
      es = !flush_c && (ex_stall_c || mem_stall_c || hazard_model());
      checks++;
      if (id_stall_c !== es) begin failures++; $display("FAIL reset/stall[%0d]: got %b want %b", i, id_stall_c, es); end
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL reset/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      checks++;
      if (load_use_cnt !== e.cnt) begin failures++; $display("FAIL reset/cnt[%0d]: got %0d want %0d", i, load_use_cnt, e.cnt); end
      if (i == 0) begin
        checks++;
        if (obs_idex() !== '0 || load_use_cnt !== 16'd0 || s_cnt !== 2'd0)
          begin failures++; $display("FAIL reset/zero: got %h cnt %0d want 0", obs_idex(), load_use_cnt); end
      end else begin
        checks++;
        if (id_ex_a !== 32'd0 || id_ex_valid !== 1'b1)
          begin failures++; $display("FAIL reset/wb_suppressed: got a=%h v=%b want a=0 v=1", id_ex_a, id_ex_valid); end
      end
    end
  endtask

  task automatic test_bypass();
    stim_t vec[$];
    exp_t e;
    logic es;
    vec.push_back(mk(1, 0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF, 1, r_add(5'd5, 5'd3, 5'd0)));
    vec.push_back(nv(r_add(5'd6, 5'd0, 5'd3)));
    foreach (vec[i]) begin
      apply(vec[i]);
      es = !flush_c && (ex_stall_c || mem_stall_c || hazard_model());
      checks++;
      if (id_stall_c !== es) begin failures++; $display("FAIL bypass/stall[%0d]: got %b want %b", i, id_stall_c, es); end
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL bypass/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      if (i == 0) begin
        checks++;
        if (id_ex_a !== 32'hDEAD_BEEF || id_ex_b !== 32'd0 || id_ex_type !== 2'b11 || id_ex_op !== 6'h20)
          begin failures++; $display("FAIL bypass/fwd: got a=%h b=%h t=%b op=%h want deadbeef 0 11 20", id_ex_a, id_ex_b, id_ex_type, id_ex_op); end
      end else begin
        checks++;
        if (id_ex_b !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass/rf_write: got %h want deadbeef", id_ex_b); end
      end
    end
  endtask

  task automatic test_load_use();
    stim_t vec[$];
    exp_t e;
    logic es;
    vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd4, 16'd0)));                          // 0 lw r4
    vec.push_back(mk(1, 0, 0, 0, 1, 5'd4, 32'h0000_1234, 1, r_add(5'd5, 5'd4, 5'd2))); // 1 hazard
    vec.push_back(nv(r_add(5'd5, 5'd4, 5'd2)));                                     // 2 issues
    vec.push_back(nv(i_op(6'b100011, 5'd2, 5'd0, 16'd8)));                          // 3 lw r0
    vec.push_back(nv(r_add(5'd6, 5'd0, 5'd0)));                                     // 4 no hazard
    vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd9, 16'd4)));                          // 5 lw r9
    vec.push_back(nv(i_op(6'b101011, 5'd2, 5'd9, 16'd0)));                          // 6 sw uses rt
    vec.push_back(nv(i_op(6'b101011, 5'd2, 5'd9, 16'd0)));                          // 7
    vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd9, 16'd4)));                          // 8 lw r9
    vec.push_back(nv(i_op(6'b001000, 5'd2, 5'd9, 16'd1)));                          // 9 addi: rt is a dest
    vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd3, 16'd0)));                          // 10 lw r3
    vec.push_back(nv(i_op(6'b000100, 5'd1, 5'd3, 16'd2)));                          // 11 beq uses rt
    foreach (vec[i]) begin
      apply(vec[i]);
      es = !flush_c && (ex_stall_c || mem_stall_c || hazard_model());
      checks++;
      if (id_stall_c !== es) begin failures++; $display("FAIL load_use/stall[%0d]: got %b want %b", i, id_stall_c, es); end
      if (i == 1 || i == 6 || i == 11) begin
        checks++;
        if (id_stall_c !== 1'b1) begin failures++; $display("FAIL load_use/stall_req[%0d]: got %b want 1", i, id_stall_c); end
      end
      if (i == 4 || i == 9) begin
        checks++;
        if (id_stall_c !== 1'b0) begin failures++; $display("FAIL load_use/no_hazard[%0d]: got %b want 0", i, id_stall_c); end
      end
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL load_use/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      checks++;
      if (load_use_cnt !== e.cnt) begin failures++; $display("FAIL load_use/cnt[%0d]: got %0d want %0d", i, load_use_cnt, e.cnt); end
      if (i == 1) begin
        checks++;
        if (id_ex_valid !== 1'b0 || load_use_cnt !== 16'd1)
          begin failures++; $display("FAIL load_use/bubble: got v=%b cnt=%0d want v=0 cnt=1", id_ex_valid, load_use_cnt); end
      end
      if (i == 2) begin
        checks++;
        if (id_ex_valid !== 1'b1 || id_ex_a !== 32'h0000_1234)
          begin failures++; $display("FAIL load_use/issue: got v=%b a=%h want v=1 a=1234", id_ex_valid, id_ex_a); end
      end
    end
  endtask

  task automatic test_stall_flush();
    stim_t vec[$];
    exp_t e;
    logic es;
    vec.push_back(nv(i_op(6'b001000, 5'd0, 5'd8, 16'h0055)));                                 // 0
    for (int k = 1; k <= 3; k++)
      vec.push_back(mk(1, 0, 0, 1, 1, 5'd7, 32'h7777_0000 + 32'(k), 1, r_add(5'd1, 5'd2, 5'd3))); // 1..3 hold
    vec.push_back(mk(1, 1, 0, 1, 0, 5'd0, 32'd0, 1, r_add(5'd1, 5'd2, 5'd3)));                // 4 flush+stall
    vec.push_back(nv(r_add(5'd1, 5'd7, 5'd0)));                                               // 5 read r7
    vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd4, 16'd0)));                                    // 6 lw r4
    vec.push_back(mk(0, 0, 0, 0, 0, 5'd0, 32'd0, 1, r_add(5'd5, 5'd4, 5'd2)));                // 7 reset mid-hazard
    vec.push_back(nv(r_add(5'd5, 5'd4, 5'd2)));                                               // 8 decodes normally
    vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd4, 16'd0)));                                    // 9 lw r4
    vec.push_back(mk(1, 0, 1, 0, 0, 5'd0, 32'd0, 1, r_add(5'd5, 5'd4, 5'd2)));                // 10 hazard under stall
    vec.push_back(nv(r_add(5'd5, 5'd4, 5'd2)));                                               // 11 bubble counted
    foreach (vec[i]) begin
      apply(vec[i]);
      es = !flush_c && (ex_stall_c || mem_stall_c || hazard_model());
      checks++;
      if (id_stall_c !== es) begin failures++; $display("FAIL stall_flush/stall[%0d]: got %b want %b", i, id_stall_c, es); end
      if (i == 4) begin
        checks++;
        if (id_stall_c !== 1'b0) begin failures++; $display("FAIL stall_flush/flush_release: got %b want 0", id_stall_c); end
      end
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL stall_flush/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      checks++;
      if (load_use_cnt !== e.cnt) begin failures++; $display("FAIL stall_flush/cnt[%0d]: got %0d want %0d", i, load_use_cnt, e.cnt); end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (id_ex_op !== 6'b001000 || id_ex_imm !== 16'h0055 || id_ex_valid !== 1'b1)
          begin failures++; $display("FAIL stall_flush/hold[%0d]: got op=%h imm=%h want 08 0055", i, id_ex_op, id_ex_imm); end
      end
      if (i == 4) begin
        checks++;
        if (id_ex_valid !== 1'b0) begin failures++; $display("FAIL stall_flush/bubble: got %b want 0", id_ex_valid); end
      end
      if (i == 5) begin
        checks++;
        if (id_ex_a !== 32'h7777_0003) begin failures++; $display("FAIL stall_flush/r7: got %h want 77770003", id_ex_a); end
      end
      if (i == 8) begin
        checks++;
        if (id_ex_valid !== 1'b1 || load_use_cnt !== 16'd0)
          begin failures++; $display("FAIL stall_flush/post_reset: got v=%b cnt=%0d want 1 0", id_ex_valid, load_use_cnt); end
      end
      if (i == 10) begin
        checks++;
        if (load_use_cnt !== 16'd0 || id_ex_is_load !== 1'b1)
          begin failures++; $display("FAIL stall_flush/no_count: got cnt=%0d ld=%b want 0 1", load_use_cnt, id_ex_is_load); end
      end
    end
  endtask

  task automatic test_types_saturation();
    stim_t vec[$];
    exp_t e;
    logic es;
    vec.push_back(mk(0, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0));
    vec.push_back(nv(32'd0));
    vec.push_back(nv({6'b000010, 26'h0000400}));
    vec.push_back(nv(i_op(6'b001000, 5'd1, 5'd2, 16'h0010)));
    for (int k = 0; k < 4; k++) begin
      vec.push_back(nv(i_op(6'b100011, 5'd1, 5'd4, 16'd0)));
      vec.push_back(nv(r_add(5'd5, 5'd4, 5'd2)));
      vec.push_back(nv(r_add(5'd5, 5'd4, 5'd2)));
    end
    foreach (vec[i]) begin
      apply(vec[i]);
      es = !flush_c && (ex_stall_c || mem_stall_c || hazard_model());
      checks++;
      if (id_stall_c !== es) begin failures++; $display("FAIL types/stall[%0d]: got %b want %b", i, id_stall_c, es); end
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL types/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      checks++;
      if (load_use_cnt !== e.cnt) begin failures++; $display("FAIL types/cnt[%0d]: got %0d want %0d", i, load_use_cnt, e.cnt); end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (id_ex_type !== 2'(i - 1) || id_ex_valid !== 1'b1)
          begin failures++; $display("FAIL types/type[%0d]: got %b want %b", i, id_ex_type, 2'(i - 1)); end
      end
      if (i == 5) begin
        checks++;
        if (s_cnt !== 2'd1) begin failures++; $display("FAIL types/small_cnt1: got %0d want 1", s_cnt); end
      end
    end
    checks++;
    if (load_use_cnt !== 16'd4) begin failures++; $display("FAIL types/cnt4: got %0d want 4", load_use_cnt); end
    checks++;
    if (s_cnt !== 2'd3) begin failures++; $display("FAIL types/saturate: got %0d want 3", s_cnt); end
  endtask

  task automatic test_param_sweep();
    stim_t vec[$];
    exp_t e;
    vec.push_back(mk(0, 0, 0, 0, 0, 5'd0, 32'd0, 0, 32'd0));
    vec.push_back(nv(r_add(5'd2, 5'd9, 5'd17)));
    vec.push_back(nv(r_add(5'd2, 5'd9, 5'd17)));
    vec.push_back(nv(r_add(5'd2, 5'd1, 5'd8)));
    foreach (vec[i]) begin
      s_wb_we = (i == 1); s_wb_dest = 3'(9); s_wb_value = 16'hBEEF;
      apply(vec[i]);
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL sweep/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      if (i == 1 || i == 2) begin
        checks++;
        if (s_a !== 16'hBEEF || s_b !== 16'hBEEF || s_valid !== 1'b1)
          begin failures++; $display("FAIL sweep/alias[%0d]: got a=%h b=%h want beef beef", i, s_a, s_b); end
      end
      if (i == 3) begin
        checks++;
        if (s_a !== 16'hBEEF || s_b !== 16'h0000)
          begin failures++; $display("FAIL sweep/r1_r8: got a=%h b=%h want beef 0000", s_a, s_b); end
      end
    end
    s_wb_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic es;
    stim_t s;
    logic [4:0] ra, rb, rc;
    for (int i = 0; i < 60; i++) begin
      ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rc = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: s.ir = i_op(6'b100011, ra, rb, 16'($urandom));
        1: s.ir = r_add(rc, ra, rb);
        2: s.ir = i_op(6'b101011, ra, rb, 16'($urandom));
        default: s.ir = i_op(6'b001000, ra, rb, 16'($urandom));
      endcase
      s.rn = 1'b1;
      s.fl = ($urandom_range(0, 15) == 0);
      s.es = ($urandom_range(0, 7) == 0);
      s.ms = ($urandom_range(0, 7) == 0);
      s.we = ($urandom_range(0, 1) == 1);
      s.dst = 5'($urandom_range(0, 7));
      s.val = $urandom;
      s.v = ($urandom_range(0, 9) != 0);
      apply(s);
      es = !flush_c && (ex_stall_c || mem_stall_c || hazard_model());
      checks++;
      if (id_stall_c !== es) begin failures++; $display("FAIL b2b/stall[%0d]: got %b want %b", i, id_stall_c, es); end
      predict(); tick();
      e = sb.pop_front();
      checks++;
      if (obs_idex() !== e.st) begin failures++; $display("FAIL b2b/idex[%0d]: got %h want %h", i, obs_idex(), e.st); end
      checks++;
      if (load_use_cnt !== e.cnt) begin failures++; $display("FAIL b2b/cnt[%0d]: got %0d want %0d", i, load_use_cnt, e.cnt); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; flush_c = 1'b0; ex_stall_c = 1'b0; mem_stall_c = 1'b0;
    wb_we = 1'b0; wb_dest = 5'd0; wb_value = 32'd0;
    if_id_valid = 1'b0; if_id_ir = 32'd0; if_id_next_pc = 32'd0;
    s_wb_we = 1'b0; s_wb_dest = 3'd0; s_wb_value = 16'd0;
    m_cur = '0; m_cnt = 16'd0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    test_reset();
    test_bypass();
    test_load_use();
    test_stall_flush();
    test_types_saturation();
    test_param_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
